// File: rtl/mem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_sram_ctrl
//   Memory-side responder for execute-stage loads and stores. Each 32-bit
//   word lives in an external asynchronous 16-bit SRAM as two half-words:
//   the low half at SRAM address {word,0} and the high half at {word,1}.
//   An access runs IDLE -> LOW -> HIGH -> DONE. Each half-access is held for
//   WAIT_CYCLES+1 cycles. ready stays low while an access is in flight.
//
// Parameters
//   ADDR_BASE   byte address mapped to SRAM word 0
//   WAIT_CYCLES extra cycles per half-access (0..15)
//   SRAM_AW     SRAM half-word address width (2..31)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   rd_en        load request
//   wr_en        store request (wins over rd_en)
//   address      byte address of the request
//   wr_data      store data
//   rd_data      load result, valid while ready=1 in DONE; held otherwise
//   ready        1 = no access in flight, 0 = freeze the pipeline
//   sram_addr    SRAM half-word address (holds between accesses)
//   sram_dq_out  SRAM write data
//   sram_dq_oe   drive enable for sram_dq_out
//   sram_dq_in   SRAM read data
//   sram_we_n    SRAM write strobe, active-low
// ---------------------------------------------------------------------------
module mem_sram_ctrl #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam logic [31:0] LP_BASE = 32'(ADDR_BASE);
    localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [3:0]         r_wait;
    logic               r_is_wr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rd_data;
    logic [SRAM_AW-1:0] r_sram_addr;

    logic               w_req;
    logic               w_last;
    logic               w_ready;
    logic               w_we_n;
    logic               w_oe;
    logic [15:0]        w_dq;
    logic [31:0]        w_offset;
    logic               w_unused;

    assign w_req    = rd_en | wr_en;
    // 32-bit subtract with wrap; bits [1:0] select a byte and are dropped,
    // bits above the SRAM word range are truncated away.
    assign w_offset = address - LP_BASE;
    assign w_unused = &{1'b0, w_offset};

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and strobes. Strobes decode the state directly so that an
    // asynchronous reset releases the SRAM bus without waiting for a clock.
    // ---------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_we_n  = 1'b1;
        w_oe    = 1'b0;
        w_dq    = 16'h0000;
        w_last  = (r_wait == LP_WAIT);
        unique case (r_state)
            S_IDLE: begin
                // The request cycle itself already freezes the pipeline.
                w_ready = ~w_req;
                if (w_req) begin
                    w_next = S_LOW;
                end
            end
            S_LOW: begin
                w_we_n = ~r_is_wr;
                w_oe   = r_is_wr;
                w_dq   = r_is_wr ? r_wdata[15:0] : 16'h0000;
                if (w_last) begin
                    w_next = S_HIGH;
                end
            end
            S_HIGH: begin
                w_we_n = ~r_is_wr;
                w_oe   = r_is_wr;
                w_dq   = r_is_wr ? r_wdata[31:16] : 16'h0000;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // The requester advances on this edge; never re-serve here.
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Access control: wait counter, operation, SRAM address, read capture
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait      <= 4'd0;
            r_is_wr     <= 1'b0;
            r_rd_data   <= 32'h0;
            r_sram_addr <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_wait <= 4'd0;
                    if (w_req) begin
                        r_is_wr     <= wr_en;
                        r_sram_addr <= {w_offset[SRAM_AW:2], 1'b0};
                    end
                end
                S_LOW: begin
                    if (w_last) begin
                        r_wait         <= 4'd0;
                        r_sram_addr[0] <= 1'b1;
                        if (!r_is_wr) begin
                            r_rd_data[15:0] <= sram_dq_in;
                        end
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_HIGH: begin
                    if (w_last) begin
                        r_wait <= 4'd0;
                        if (!r_is_wr) begin
                            r_rd_data[31:16] <= sram_dq_in;
                        end
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_DONE: begin
                    r_wait <= 4'd0;
                end
                default: begin
                    r_wait <= 4'd0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Store data capture (data only, no reset needed; gated by the strobes)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_req) begin
            r_wdata <= wr_data;
        end
    end

    assign ready       = w_ready;
    assign rd_data     = r_rd_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = w_dq;
    assign sram_dq_oe  = w_oe;
    assign sram_we_n   = w_we_n;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
module tb_mem_sram_ctrl;

    localparam int W   = 1;
    localparam int LAT = 2 * (W + 1) + 1;

    logic        clk = 1'b0;
    logic        rst;

    logic        rd_en, wr_en;
    logic [31:0] address, wr_data, rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        rd_en0, wr_en0;
    logic [31:0] address0, wr_data0, rd_data0;
    logic        ready0;
    logic [17:0] sram_addr0;
    logic [15:0] sram_dq_out0, sram_dq_in0;
    logic        sram_dq_oe0, sram_we_n0;

    logic [15:0] sram_mem  [0:262143];
    logic [15:0] sram_mem0 [0:262143];

    logic [15:0] exp_mem  [int];
    logic [15:0] exp_mem0 [int];
    logic [31:0] last_rd;
    logic [31:0] written [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(W), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    mem_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(0), .SRAM_AW(18)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd_en0), .wr_en(wr_en0),
        .address(address0), .wr_data(wr_data0), .rd_data(rd_data0), .ready(ready0),
        .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_oe(sram_dq_oe0),
        .sram_dq_in(sram_dq_in0), .sram_we_n(sram_we_n0)
    );

    // Asynchronous SRAM models: combinational read, write while we_n is low.
    assign sram_dq_in  = sram_mem[sram_addr];
    assign sram_dq_in0 = sram_mem0[sram_addr0];

    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
        if (!sram_we_n0) sram_mem0[sram_addr0] <= sram_dq_out0;
    end

    // Half-word index of the low half of the word addressed by byte address a.
    function automatic int word_base(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'(((off >> 2) * 32'd2) % 32'd262144);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the WAIT_CYCLES=1 instance, request held through DONE.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input string tag,
                          output logic [31:0] rdv);
        int base;
        int half;
        bit is_wr;
        logic [31:0] exp;
        is_wr = wr;
        base  = word_base(a);
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = a; wr_data = d;
        #1;
        chk({tag, "_req_ready"}, 32'(ready), 32'd0);
        for (int c = 2; c <= LAT; c++) begin
            @(negedge clk);
            half = (c <= W + 2) ? 0 : 1;
            chk({tag, "_busy"}, 32'(ready), 32'd0);
            chk({tag, "_addr"}, 32'(sram_addr), 32'(base + half));
            chk({tag, "_we_n"}, 32'(sram_we_n), 32'(!is_wr));
            chk({tag, "_oe"}, 32'(sram_dq_oe), 32'(is_wr));
            if (is_wr)
                chk({tag, "_dq"}, 32'(sram_dq_out), half ? 32'(d[31:16]) : 32'(d[15:0]));
            // Inputs other than the enables may change freely once latched.
            address = $urandom;
            wr_data = $urandom;
        end
        @(negedge clk);
        chk({tag, "_done_ready"}, 32'(ready), 32'd1);
        chk({tag, "_done_we_n"}, 32'(sram_we_n), 32'd1);
        rdv = rd_data;
        if (is_wr) begin
            exp_mem[base]     = d[15:0];
            exp_mem[base + 1] = d[31:16];
            chk({tag, "_rd_hold"}, rd_data, last_rd);
            chk({tag, "_mem_lo"}, 32'(sram_mem[base]), 32'(d[15:0]));
            chk({tag, "_mem_hi"}, 32'(sram_mem[base + 1]), 32'(d[31:16]));
        end else begin
            exp = {exp_mem[base + 1], exp_mem[base]};
            last_rd = exp;
            chk({tag, "_rd_data"}, rd_data, exp);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
        #1;
        chk({tag, "_no_reserve"}, 32'(ready), 32'd1);
        chk({tag, "_idle_we_n"}, 32'(sram_we_n), 32'd1);
    endtask

    // One access on the WAIT_CYCLES=0 instance; checks latency and load data.
    task automatic access0(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input string tag);
        int n;
        int base;
        base = word_base(a);
        @(negedge clk);
        rd_en0 = !wr; wr_en0 = wr; address0 = a; wr_data0 = d;
        #1;
        n = 0;
        while (ready0 !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 32'(n), 32'd3);
        if (wr) begin
            exp_mem0[base]     = d[15:0];
            exp_mem0[base + 1] = d[31:16];
        end else begin
            chk({tag, "_rd_data"}, rd_data0, {exp_mem0[base + 1], exp_mem0[base]});
        end
        @(posedge clk);
        #1;
        rd_en0 = 1'b0; wr_en0 = 1'b0;
    endtask

    initial begin
        logic [31:0] rdv;
        logic [31:0] a;
        logic [31:0] d;
        bit          both;
        rst = 1'b0;
        rd_en = 0; wr_en = 0; address = 0; wr_data = 0;
        rd_en0 = 0; wr_en0 = 0; address0 = 0; wr_data0 = 0;
        last_rd = 32'h0;

        // Reset values with the clock running
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        rst = 1'b1;

        // Directed store / load / both-enables
        access(1, 0, 32'd1032, 32'hDEADBEEF, "store", rdv);
        chk("store_sram4", 32'(sram_mem[4]), 32'h0000BEEF);
        chk("store_sram5", 32'(sram_mem[5]), 32'h0000DEAD);
        access(0, 1, 32'd1032, 32'h0, "load", rdv);
        chk("load_value", rdv, 32'hDEADBEEF);
        access(1, 1, 32'd1024, 32'h12345678, "both", rdv);
        chk("both_sram0", 32'(sram_mem[0]), 32'h00005678);
        chk("both_sram1", 32'(sram_mem[1]), 32'h00001234);
        access(0, 1, 32'd1026, 32'h0, "both_rb", rdv);
        chk("both_rb_value", rdv, 32'h12345678);
        written.push_back(32'd1032);
        written.push_back(32'd1024);

        // Quiet bus with no request
        repeat (3) @(negedge clk);
        chk("quiet_ready", 32'(ready), 32'd1);
        chk("quiet_we_n", 32'(sram_we_n), 32'd1);
        chk("quiet_oe", 32'(sram_dq_oe), 32'd0);

        // Zero wait states: ready low for 3 cycles
        access0(1, 32'd1032, 32'hA5A55A5A, "w0_store");
        access0(0, 32'd1032, 32'h0, "w0_load");
        access0(1, 32'd4096, 32'h0BADF00D, "w0_store2");
        access0(0, 32'd4097, 32'h0, "w0_load2");

        // Asynchronous reset during the HIGH phase of a write
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1064; wr_data = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        chk("abort_in_high_addr", 32'(sram_addr), 32'(word_base(32'd1064) + 1));
        chk("abort_in_high_we_n", 32'(sram_we_n), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_rd_data", rd_data, 32'h0);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        wr_en = 1'b0;
        #1;
        chk("abort_idle_ready", 32'(ready), 32'd1);
        last_rd = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        access(1, 0, 32'd1064, 32'h13579BDF, "post_rst_wr", rdv);
        access(0, 1, 32'd1064, 32'h0, "post_rst_rd", rdv);
        chk("post_rst_value", rdv, 32'h13579BDF);
        written.push_back(32'd1064);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 9) == 0) a = $urandom;
                else a = 32'd1024 + 32'(4 * $urandom_range(0, 4095)) + 32'($urandom_range(0, 3));
                d = $urandom;
                both = ($urandom_range(0, 1) == 1);
                access(1, both, a, d, "rnd_wr", rdv);
                written.push_back(a);
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
                a = (a & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
                access(0, 1, a, 32'h0, "rnd_rd", rdv);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
